// File: rtl/fetch_redirect_pkg.sv
// fetch_pkg: shared FSM state type and reset constant for the fetch redirect unit
package fetch_pkg;
   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      RECOVER = 2'd2
   } fetch_state_e;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_redirect_if.sv
// fetch_redirect_if: predictor, EX-resolution, fetch and predictor-update signals of the fetch redirect unit
interface fetch_redirect_if;
   logic [31:0] predicted_pc;
   logic        prediction;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_pc;
   logic [31:0] current_pc;
   logic        if_valid;
   logic        if_pred_taken;
   logic [31:0] if_pred_pc;
   logic        is_control_flow;
   logic        is_correct;
   logic [31:0] pc_to_update;
   logic [31:0] branch_target;
   logic        flush;
   modport master (
      output predicted_pc, prediction, stall, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_pc,
      input  current_pc, if_valid, if_pred_taken, if_pred_pc, is_control_flow, is_correct, pc_to_update,
             branch_target, flush
   );
   modport slave (
      input  predicted_pc, prediction, stall, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_pc,
      output current_pc, if_valid, if_pred_taken, if_pred_pc, is_control_flow, is_correct, pc_to_update,
             branch_target, flush
   );
endinterface

// File: rtl/fetch_redirect_check.sv
// redirect_check: detects a mispredicted EX control-flow instruction and selects the corrected fetch PC
module redirect_check (
   input  logic        ex_valid,
   input  logic        run,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_pc,
   output logic        mispredict,
   output logic [31:0] redirect_pc
);
   // direction wrong, or taken with the wrong predicted target; +4 wraps naturally at 32 bits
   always_comb begin
      mispredict  = ex_valid & run & ((ex_pred_taken != ex_taken) | (ex_taken & (ex_pred_pc != ex_target)));
      redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
   end
endmodule

// File: rtl/fetch_redirect.sv
// fetch_redirect: PC generation with mispredict recovery (BOOT/RUN/RECOVER); FETCH_STATS_EN adds branch/mispredict counters
module fetch_redirect
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   fetch_redirect_if.slave bus
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
`endif
);
   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt, redirect_pc;
   logic         mispredict, run;

   assign run = (state == RUN);

   redirect_check u_check (
      .ex_valid      (bus.ex_valid),
      .run           (run),
      .ex_pc         (bus.ex_pc),
      .ex_taken      (bus.ex_taken),
      .ex_target     (bus.ex_target),
      .ex_pred_taken (bus.ex_pred_taken),
      .ex_pred_pc    (bus.ex_pred_pc),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc)
   );

   // state and PC registers; reset discards any pending redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // next state, PC priority (mispredict > stall > prediction) and all outward signals
   always_comb begin
      state_nxt           = (run && mispredict) ? RECOVER : RUN;
      pc_nxt              = mispredict ? redirect_pc : (state == BOOT || bus.stall) ? pc : bus.predicted_pc;
      bus.current_pc      = pc;
      bus.if_valid        = (state != BOOT);
      bus.if_pred_taken   = bus.prediction;
      bus.if_pred_pc      = bus.predicted_pc;
      bus.is_control_flow = bus.ex_valid & run;
      bus.is_correct      = bus.ex_taken;
      bus.pc_to_update    = bus.ex_pc;
      bus.branch_target   = bus.ex_target;
      bus.flush           = mispredict;
   end

`ifdef FETCH_STATS_EN
   // free-running wrap-around counters of predictor updates and mispredicts
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count     <= 32'd0;
         mispredict_count <= 32'd0;
      end else begin
         if (bus.is_control_flow) branch_count <= branch_count + 32'd1;
         if (mispredict) mispredict_count <= mispredict_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_redirect.sv
// tb_fetch_redirect: directed scoreboard bench for fetch_redirect (FETCH_STATS_EN also checks counters)
module tb_fetch_redirect;
   typedef struct packed {
      logic [31:0] pc, upd, tgt, ppc;
      logic        ifv, fl, icf, ic, pt;
   } exp_t;

   logic clk, reset;
   int   checks, failures;
   exp_t  exp_q[$];
   string name_q[$];
   exp_t  e;
   string n;
`ifdef FETCH_STATS_EN
   logic [31:0] branch_count, mispredict_count;
`endif

   fetch_redirect_if bus();

   fetch_redirect #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_STATS_EN
      ,
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] xp);
      checks++;
      if (act !== xp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, xp);
      end
   endtask

   task automatic cyc(input string nm, input logic rs, input logic [31:0] ppc, input logic pt, input logic st,
                      input logic ev, input logic [31:0] epc, input logic et, input logic [31:0] etgt,
                      input logic ept, input logic [31:0] eppc,
                      input logic [31:0] xpc, input logic xifv, input logic xfl, input logic xicf);
      exp_t x;
      @(posedge clk);
      #1;
      reset             = rs;
      bus.predicted_pc  = ppc;
      bus.prediction    = pt;
      bus.stall         = st;
      bus.ex_valid      = ev;
      bus.ex_pc         = epc;
      bus.ex_taken      = et;
      bus.ex_target     = etgt;
      bus.ex_pred_taken = ept;
      bus.ex_pred_pc    = eppc;
      x.pc  = xpc;
      x.ifv = xifv;
      x.fl  = xfl;
      x.icf = xicf;
      x.ic  = et;
      x.upd = epc;
      x.tgt = etgt;
      x.ppc = ppc;
      x.pt  = pt;
      exp_q.push_back(x);
      name_q.push_back(nm);
   endtask

   task automatic mid_reset(input string nm);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk({nm, ".async_pc"}, bus.current_pc, 32'h0);
      chk({nm, ".async_ifv"}, {31'd0, bus.if_valid}, 32'd0);
      chk({nm, ".async_flush"}, {31'd0, bus.flush}, 32'd0);
      chk({nm, ".async_icf"}, {31'd0, bus.is_control_flow}, 32'd0);
`ifdef FETCH_STATS_EN
      chk({nm, ".async_bcnt"}, branch_count, 32'd0);
      chk({nm, ".async_mcnt"}, mispredict_count, 32'd0);
`endif
   endtask

   // monitor: compare every presented output set against the queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk({n, ".current_pc"}, bus.current_pc, e.pc);
            chk({n, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, e.ifv});
            chk({n, ".flush"}, {31'd0, bus.flush}, {31'd0, e.fl});
            chk({n, ".is_control_flow"}, {31'd0, bus.is_control_flow}, {31'd0, e.icf});
            chk({n, ".is_correct"}, {31'd0, bus.is_correct}, {31'd0, e.ic});
            chk({n, ".pc_to_update"}, bus.pc_to_update, e.upd);
            chk({n, ".branch_target"}, bus.branch_target, e.tgt);
            chk({n, ".if_pred_pc"}, bus.if_pred_pc, e.ppc);
            chk({n, ".if_pred_taken"}, {31'd0, bus.if_pred_taken}, {31'd0, e.pt});
         end
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      bus.predicted_pc = 32'h0;
      bus.prediction = 1'b0;
      bus.stall = 1'b0;
      bus.ex_valid = 1'b0;
      bus.ex_pc = 32'h0;
      bus.ex_taken = 1'b0;
      bus.ex_target = 32'h0;
      bus.ex_pred_taken = 1'b0;
      bus.ex_pred_pc = 32'h0;
      //   name         rs  ppc           pt st ev epc           et tgt           ept eppc          xpc           ifv fl icf
      cyc("rst",        1, 32'h4,        0, 0, 1, 32'h40,       1, 32'h100,      0, 32'h0,        32'h0,        0, 0, 0);
      cyc("boot",       0, 32'h4,        1, 0, 1, 32'h40,       1, 32'h100,      0, 32'h0,        32'h0,        0, 0, 0);
      cyc("run0",       0, 32'h4,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0);
      cyc("run4",       0, 32'h8,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0);
      cyc("mp_dir",     0, 32'hC,        0, 0, 1, 32'h40,       1, 32'h100,      0, 32'h0,        32'h8,        1, 1, 1);
      cyc("recov1",     0, 32'h104,      0, 0, 1, 32'h40,       1, 32'h100,      0, 32'h0,        32'h100,      1, 0, 0);
      cyc("mp_tgt",     0, 32'h108,      1, 0, 1, 32'h80,       1, 32'h200,      1, 32'h180,      32'h104,      1, 1, 1);
      cyc("recov2",     0, 32'h204,      0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h200,      1, 0, 0);
      cyc("ok_nt_st",   0, 32'h208,      0, 1, 1, 32'h90,       0, 32'h300,      0, 32'h999,      32'h204,      1, 0, 1);
      cyc("ok_t",       0, 32'h208,      1, 0, 1, 32'h94,       1, 32'h300,      1, 32'h300,      32'h204,      1, 0, 1);
      cyc("mp_wrap",    0, 32'h20C,      0, 1, 1, 32'hFFFF_FFFC, 0, 32'h20,      1, 32'h10,       32'h208,      1, 1, 1);
      cyc("recov3",     0, 32'h4,        0, 0, 1, 32'hFFFF_FFFC, 0, 32'h20,      1, 32'h10,       32'h0,        1, 0, 0);
      cyc("mp_pre_rst", 0, 32'h8,        0, 0, 1, 32'h50,       1, 32'h700,      0, 32'h0,        32'h4,        1, 1, 1);
      cyc("recov4",     0, 32'h704,      0, 0, 1, 32'h50,       1, 32'h700,      0, 32'h0,        32'h700,      1, 0, 0);
      @(negedge clk);
`ifdef FETCH_STATS_EN
      chk("stats.bcnt", branch_count, 32'd6);
      chk("stats.mcnt", mispredict_count, 32'd4);
`endif
      mid_reset("rst_recover");
      cyc("rst2",       1, 32'h4,        0, 0, 1, 32'h50,       1, 32'h700,      0, 32'h0,        32'h0,        0, 0, 0);
      cyc("boot2",      0, 32'h4,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0);
      cyc("run2",       0, 32'h4,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0);
      cyc("mp_rst",     0, 32'h8,        0, 0, 1, 32'h60,       1, 32'h900,      0, 32'h0,        32'h4,        1, 1, 1);
      mid_reset("rst_mispredict");
      cyc("rst3",       1, 32'h8,        0, 0, 1, 32'h60,       1, 32'h900,      0, 32'h0,        32'h0,        0, 0, 0);
      cyc("boot3",      0, 32'h4,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0);
      cyc("run3",       0, 32'h4,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0);
      repeat (2) @(posedge clk);
      chk("queue_drain", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports predicted_pc  input  32 and prediction  input  1, both from the branch predictor for current_pc.
REQ-005 SHALL have port stall  input  1  hazard hold; PC keeps its value while high.
REQ-006 SHALL have ports ex_valid  input  1, ex_pc  input  32, ex_taken  input  1, ex_target  input  32 for the control-flow instruction resolved in EX.
REQ-007 SHALL have ports ex_pred_taken  input  1 and ex_pred_pc  input  32, carrying the prediction made for that EX instruction.
REQ-008 SHALL have ports current_pc  output  32, if_valid  output  1, if_pred_taken  output  1, if_pred_pc  output  32 toward imem, predictor and IF/ID.
REQ-009 SHALL have ports is_control_flow  output  1, is_correct  output  1, pc_to_update  output  32, branch_target  output  32 as the predictor update bus.
REQ-010 SHALL have port flush  output  1, which kills IF/ID and ID/EX contents.

Function
REQ-011 SHALL hold a 3-state FSM: BOOT, RUN, RECOVER.
REQ-012 SHALL leave BOOT for RUN after one cycle; in BOOT, if_valid=0 and PC does not advance.
REQ-013 SHALL compute mispredict = ex_valid & state==RUN & ((ex_pred_taken != ex_taken) | (ex_taken & ex_pred_pc != ex_target)).
REQ-014 SHALL, on mispredict, drive flush=1 combinationally, load PC with ex_taken ? ex_target : ex_pc+4, and enter RECOVER.
REQ-015 SHALL, in RECOVER, mask ex_valid (no mispredict, no predictor update), keep flush=0, and return to RUN after exactly one cycle.
REQ-016 SHALL, in RUN without mispredict, load PC with predicted_pc when stall=0 and hold PC when stall=1.
REQ-017 SHALL give PC-load priority: reset > mispredict > stall > predicted_pc; mispredict overrides stall.
REQ-018 SHALL drive if_pred_taken=prediction and if_pred_pc=predicted_pc combinationally; if_valid=1 in RUN and RECOVER.
REQ-019 SHALL drive is_control_flow = ex_valid & state==RUN, pc_to_update=ex_pc, branch_target=ex_target, is_correct=ex_taken (the predictor stores it as its taken bit).
REQ-020 SHALL wrap ex_pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-021 SHALL on reset set PC=RESET_PC, state=BOOT, flush=0, if_valid=0, is_control_flow=0, immediately and independent of clk.
REQ-022 SHALL, if reset asserts during RECOVER or in a mispredict cycle, discard the redirect and restart from RESET_PC.

Configuration
REQ-023 SHALL, with FETCH_STATS_EN defined, add outputs branch_count and mispredict_count (32-bit, wrapping, reset to 0), incremented on is_control_flow and mispredict respectively.
REQ-024 SHALL, without FETCH_STATS_EN, omit those ports and counters entirely.

Structure
REQ-025 SHALL place the FSM state typedef, state encodings and the default RESET_PC constant in shared package fetch_pkg.
REQ-026 SHALL implement mispredict detection and corrected-PC selection in combinational sub-module redirect_check.

Verification
REQ-027 Reset then release -> current_pc=0, if_valid=0 one cycle, then if_valid=1, PC follows predicted_pc 0x4, 0x8.
REQ-028 ex_valid=1, ex_pc=0x40, ex_taken=1, ex_target=0x100, ex_pred_taken=0 -> flush=1 that cycle, next current_pc=0x100, state RECOVER, is_control_flow=1, is_correct=1.
REQ-029 ex_taken=1, ex_target=0x200, ex_pred_taken=1, ex_pred_pc=0x180 -> mispredict, next current_pc=0x200.
REQ-030 Correct not-taken prediction with stall=1 -> no flush, PC held, predictor update still issued with is_correct=0.
REQ-031 Mispredict with stall=1, ex_pc=0xFFFF_FFFC, ex_taken=0 -> next current_pc=0x0; ex_valid in following RECOVER cycle ignored.
REQ-032 Reset asserted mid-RECOVER -> current_pc=RESET_PC immediately, state BOOT; with FETCH_STATS_EN counters read 0.
